// File: rtl/anabellek_paket.sv
// Shared types and constants for the main-memory responder: FSM states,
// requester identities and block geometry.
package anabellek_paket;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    AKTAR = 2'd1,
    YANIT = 2'd2
  } durum_t;

  typedef enum logic {
    GETIR  = 1'b0,
    BELLEK = 1'b1
  } sahip_t;

  localparam int OBEK_KELIME = 4;  // beats per block
  localparam int OBEK_HIZA   = 4;  // low address bits dropped for block alignment
  localparam int SAYAC_BIT   = $clog2(OBEK_KELIME);

endpackage

// File: rtl/anabellek_hakem.sv
// Two-way round-robin arbiter: a lone requester always wins, a conflict goes
// to whichever requester did not win last time.
module anabellek_hakem
  import anabellek_paket::*;
(
  input  logic   getir_istek,
  input  logic   bellek_istek,
  input  sahip_t son_kazanan,
  output logic   kabul,
  output sahip_t kazanan
);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    kabul   = getir_istek | bellek_istek;
    kazanan = GETIR;
    if (getir_istek && bellek_istek) begin
      kazanan = (son_kazanan == GETIR) ? BELLEK : GETIR;
    end else if (bellek_istek) begin
      kazanan = BELLEK;
    end
  end

endmodule

// File: rtl/anabellek_yanitlayici.sv
// Main-memory responder: arbitrates fetch/memory-stage block requests and
// moves each block as four in-order word beats over the RAM port.
module anabellek_yanitlayici
  import anabellek_paket::*;
#(
  parameter int OBEK_BIT   = 128,
  parameter int KELIME_BIT = 32,
  parameter int ADRES_BIT  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  getir_asamasi_istek_i,
  input  logic [ADRES_BIT-1:0]  getir_adres_i,
  input  logic                  getir_oku_i,
  output logic                  anabellek_musait_o,
  output logic                  getir_asamasina_veri_hazir_o,
  output logic [OBEK_BIT-1:0]   okunan_obek_o,

  input  logic                  bellek_asamasi_istek_i,
  input  logic [ADRES_BIT-1:0]  bellek_adres_i,
  input  logic                  bellek_oku_i,
  input  logic                  bellek_yaz_i,
  input  logic [OBEK_BIT-1:0]   bellek_yazilacak_obek_i,
  output logic                  bellek_asamasina_veri_hazir_o,

  output logic                  ram_istek_o,
  output logic [ADRES_BIT-1:0]  ram_adres_o,
  output logic                  ram_yaz_o,
  output logic [KELIME_BIT-1:0] ram_yaz_veri_o,
  input  logic                  ram_gecerli_i,
  input  logic [KELIME_BIT-1:0] ram_okunan_veri_i
);

  localparam logic [ADRES_BIT-1:0] HIZA_MASKESI = ~ADRES_BIT'((1 << OBEK_HIZA) - 1);
  localparam logic [SAYAC_BIT-1:0] SON_SAYAC    = SAYAC_BIT'(OBEK_KELIME - 1);

  durum_t                durum, durum_sonraki;
  logic [SAYAC_BIT-1:0]  sayac;
  sahip_t                son_kazanan, sahip, kazanan;
  logic                  kabul, yaz_r, aktar, son_vurus;
  logic                  getir_gecerli, bellek_gecerli;
  logic [ADRES_BIT-1:0]  taban_adres, secili_adres;
  logic [OBEK_BIT-1:0]   yaz_obek, tampon, tampon_sonraki, okunan_obek_r;

  // A request counts only when it carries a command.
  assign getir_gecerli  = getir_asamasi_istek_i & getir_oku_i;
  assign bellek_gecerli = bellek_asamasi_istek_i & (bellek_oku_i | bellek_yaz_i);

  anabellek_hakem u_hakem (
    .getir_istek  (getir_gecerli),
    .bellek_istek (bellek_gecerli),
    .son_kazanan  (son_kazanan),
    .kabul        (kabul),
    .kazanan      (kazanan)
  );

  assign aktar        = (durum == AKTAR);
  assign son_vurus    = (sayac == SON_SAYAC);
  assign secili_adres = (kazanan == BELLEK) ? bellek_adres_i : getir_adres_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) durum <= BOSTA;
    else        durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    unique case (durum)
      BOSTA:   if (kabul) durum_sonraki = AKTAR;
      AKTAR:   if (ram_gecerli_i && son_vurus) durum_sonraki = YANIT;
      YANIT:   durum_sonraki = BOSTA;
      default: durum_sonraki = BOSTA;
    endcase
  end

  // Current beat's read word dropped into its slot of the assembly buffer.
  always_comb begin
    tampon_sonraki = tampon;
    tampon_sonraki[int'(sayac)*KELIME_BIT +: KELIME_BIT] = ram_okunan_veri_i;
  end

  // NOTE: the block buffers are plain registers, reset so the shared read bus starts at zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sayac         <= '0;
      son_kazanan   <= GETIR;
      sahip         <= GETIR;
      yaz_r         <= 1'b0;
      taban_adres   <= '0;
      yaz_obek      <= '0;
      tampon        <= '0;
      okunan_obek_r <= '0;
    end else begin
      unique case (durum)
        BOSTA: begin
          if (kabul) begin
            sahip       <= kazanan;
            son_kazanan <= kazanan;
            // Memory stage with both commands set is treated as a write.
            yaz_r       <= (kazanan == BELLEK) && bellek_yaz_i;
            taban_adres <= secili_adres & HIZA_MASKESI;
            yaz_obek    <= bellek_yazilacak_obek_i;
            sayac       <= '0;
          end
        end
        AKTAR: begin
          if (ram_gecerli_i) begin
            sayac <= sayac + 1'b1;
            if (!yaz_r) begin
              tampon <= tampon_sonraki;
              if (son_vurus) okunan_obek_r <= tampon_sonraki;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign anabellek_musait_o            = (durum == BOSTA);
  assign getir_asamasina_veri_hazir_o  = (durum == YANIT) && (sahip == GETIR);
  assign bellek_asamasina_veri_hazir_o = (durum == YANIT) && (sahip == BELLEK);
  assign okunan_obek_o                 = okunan_obek_r;

  assign ram_istek_o    = aktar;
  assign ram_yaz_o      = aktar && yaz_r;
  assign ram_adres_o    = aktar ? (taban_adres + ADRES_BIT'({sayac, 2'b00})) : '0;
  assign ram_yaz_veri_o = (aktar && yaz_r) ? yaz_obek[int'(sayac)*KELIME_BIT +: KELIME_BIT] : '0;

endmodule

// File: tb/tb_anabellek_yanitlayici.sv
// Directed bench for the main-memory responder with a small word RAM model.
module tb_anabellek_yanitlayici;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         getir_asamasi_istek_i, getir_oku_i;
  logic [31:0]  getir_adres_i;
  logic         anabellek_musait_o, getir_hazir, bellek_hazir;
  logic [127:0] okunan_obek_o;
  logic         bellek_asamasi_istek_i, bellek_oku_i, bellek_yaz_i;
  logic [31:0]  bellek_adres_i;
  logic [127:0] bellek_yazilacak_obek_i;
  logic         ram_istek_o, ram_yaz_o, ram_gecerli_i;
  logic [31:0]  ram_adres_o, ram_yaz_veri_o, ram_okunan_veri_i;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLOK_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] BLOK_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
  localparam logic [127:0] BLOK_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
  localparam logic [127:0] BLOK_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
  localparam logic [127:0] YAZ_1  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] YAZ_2  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};

  logic [31:0] mem [256];
  logic        stall;
  logic [31:0] log_adres[$];
  logic [31:0] log_veri[$];
  bit          log_yaz[$];

  anabellek_yanitlayici dut (
    .clk_i                         (clk_i),
    .rst_i                         (rst_i),
    .getir_asamasi_istek_i         (getir_asamasi_istek_i),
    .getir_adres_i                 (getir_adres_i),
    .getir_oku_i                   (getir_oku_i),
    .anabellek_musait_o            (anabellek_musait_o),
    .getir_asamasina_veri_hazir_o  (getir_hazir),
    .okunan_obek_o                 (okunan_obek_o),
    .bellek_asamasi_istek_i        (bellek_asamasi_istek_i),
    .bellek_adres_i                (bellek_adres_i),
    .bellek_oku_i                  (bellek_oku_i),
    .bellek_yaz_i                  (bellek_yaz_i),
    .bellek_yazilacak_obek_i       (bellek_yazilacak_obek_i),
    .bellek_asamasina_veri_hazir_o (bellek_hazir),
    .ram_istek_o                   (ram_istek_o),
    .ram_adres_o                   (ram_adres_o),
    .ram_yaz_o                     (ram_yaz_o),
    .ram_yaz_veri_o                (ram_yaz_veri_o),
    .ram_gecerli_i                 (ram_gecerli_i),
    .ram_okunan_veri_i             (ram_okunan_veri_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: answers every beat immediately unless the bench stalls it.
  assign ram_gecerli_i     = ram_istek_o && !stall;
  assign ram_okunan_veri_i = mem[ram_adres_o[9:2]];

  always @(posedge clk_i) begin
    if (ram_istek_o && ram_gecerli_i) begin
      log_adres.push_back(ram_adres_o);
      log_yaz.push_back(ram_yaz_o);
      log_veri.push_back(ram_yaz_veri_o);
    end
  end

  task automatic bekle_hazir(input bit bellek_mi, output int c);
    c = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      if ((bellek_mi ? bellek_hazir : getir_hazir) === 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  task automatic bosalt();
    getir_asamasi_istek_i  = 1'b0;
    getir_oku_i            = 1'b0;
    bellek_asamasi_istek_i = 1'b0;
    bellek_oku_i           = 1'b0;
    bellek_yaz_i           = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #3;
    checks++; if (anabellek_musait_o !== 1'b1) begin errors++; $display("FAIL reset_musait: got %b expected 1", anabellek_musait_o); end
    checks++; if ({getir_hazir, bellek_hazir, ram_istek_o, ram_yaz_o} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {getir_hazir, bellek_hazir, ram_istek_o, ram_yaz_o}); end
    checks++; if (okunan_obek_o !== 128'h0) begin errors++; $display("FAIL reset_obek: got %h expected 0", okunan_obek_o); end
    checks++; if ({ram_adres_o, ram_yaz_veri_o} !== 64'h0) begin errors++; $display("FAIL reset_ram_bus: got %h expected 0", {ram_adres_o, ram_yaz_veri_o}); end
    @(negedge clk_i) rst_i = 1'b1;
  endtask

  task automatic test_fetch_read();
    int c, n0;
    @(posedge clk_i); #1;
    n0 = log_adres.size();
    getir_adres_i = 32'h0000_1234; getir_oku_i = 1'b1; getir_asamasi_istek_i = 1'b1;
    bekle_hazir(1'b0, c);
    checks++; if (c !== 5) begin errors++; $display("FAIL fetch_latency: got %0d expected 5", c); end
    checks++; if (okunan_obek_o !== BLOK_A) begin errors++; $display("FAIL fetch_obek: got %h expected %h", okunan_obek_o, BLOK_A); end
    checks++; if (bellek_hazir !== 1'b0) begin errors++; $display("FAIL fetch_wrong_strobe: got %b expected 0", bellek_hazir); end
    bosalt();
    @(posedge clk_i); #1;
    checks++; if (getir_hazir !== 1'b0) begin errors++; $display("FAIL fetch_strobe_width: got %b expected 0", getir_hazir); end
    checks++; if (anabellek_musait_o !== 1'b1) begin errors++; $display("FAIL fetch_musait_after: got %b expected 1", anabellek_musait_o); end
    checks++; if (log_adres.size() - n0 !== 4) begin errors++; $display("FAIL fetch_beat_count: got %0d expected 4", log_adres.size() - n0); end
    for (int i = 0; i < 4 && n0 + i < log_adres.size(); i++) begin
      checks++;
      if (log_adres[n0+i] !== 32'h1230 + 32'(4*i) || log_yaz[n0+i] !== 1'b0) begin
        errors++; $display("FAIL fetch_beat%0d: got adr %h yaz %b expected adr %h yaz 0", i, log_adres[n0+i], log_yaz[n0+i], 32'h1230 + 32'(4*i));
      end
    end
  endtask

  task automatic test_mem_write();
    int c, n0;
    logic [127:0] blk;
    blk = YAZ_1;
    @(posedge clk_i); #1;
    n0 = log_adres.size();
    bellek_adres_i = 32'h100; bellek_yazilacak_obek_i = blk; bellek_yaz_i = 1'b1; bellek_asamasi_istek_i = 1'b1;
    bekle_hazir(1'b1, c);
    checks++; if (c !== 5) begin errors++; $display("FAIL write_latency: got %0d expected 5", c); end
    checks++; if (okunan_obek_o !== BLOK_A) begin errors++; $display("FAIL write_obek_kept: got %h expected %h", okunan_obek_o, BLOK_A); end
    checks++; if (getir_hazir !== 1'b0) begin errors++; $display("FAIL write_wrong_strobe: got %b expected 0", getir_hazir); end
    bosalt();
    @(posedge clk_i); #1;
    checks++; if (bellek_hazir !== 1'b0) begin errors++; $display("FAIL write_strobe_width: got %b expected 0", bellek_hazir); end
    checks++; if (log_adres.size() - n0 !== 4) begin errors++; $display("FAIL write_beat_count: got %0d expected 4", log_adres.size() - n0); end
    for (int i = 0; i < 4 && n0 + i < log_adres.size(); i++) begin
      checks++;
      if (log_adres[n0+i] !== 32'h100 + 32'(4*i) || log_yaz[n0+i] !== 1'b1 || log_veri[n0+i] !== blk[32*i +: 32]) begin
        errors++; $display("FAIL write_beat%0d: got adr %h yaz %b data %h expected adr %h yaz 1 data %h",
                           i, log_adres[n0+i], log_yaz[n0+i], log_veri[n0+i], 32'h100 + 32'(4*i), blk[32*i +: 32]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int sira[4];
    int n;
    bit getir_tekrar, bellek_tekrar;
    rst_i = 1'b0;
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    n = 0; getir_tekrar = 1'b0; bellek_tekrar = 1'b0;
    getir_adres_i  = 32'h200; getir_oku_i  = 1'b1; getir_asamasi_istek_i  = 1'b1;
    bellek_adres_i = 32'h300; bellek_oku_i = 1'b1; bellek_asamasi_istek_i = 1'b1;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(posedge clk_i); #1;
      if (getir_tekrar)  begin getir_asamasi_istek_i  = 1'b1; getir_tekrar  = 1'b0; end
      if (bellek_tekrar) begin bellek_asamasi_istek_i = 1'b1; bellek_tekrar = 1'b0; end
      if (getir_hazir === 1'b1) begin
        checks++; if (okunan_obek_o !== BLOK_B) begin errors++; $display("FAIL rr_fetch_obek%0d: got %h expected %h", n, okunan_obek_o, BLOK_B); end
        sira[n] = 0; n++;
        getir_asamasi_istek_i = 1'b0; getir_tekrar = 1'b1;
      end else if (bellek_hazir === 1'b1) begin
        checks++; if (okunan_obek_o !== BLOK_C) begin errors++; $display("FAIL rr_mem_obek%0d: got %h expected %h", n, okunan_obek_o, BLOK_C); end
        sira[n] = 1; n++;
        bellek_asamasi_istek_i = 1'b0; bellek_tekrar = 1'b1;
      end
    end
    bosalt();
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_grant_count: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (sira[i] !== ((i % 2 == 0) ? 1 : 0)) begin errors++; $display("FAIL rr_order%0d: got owner %0d expected %0d (1=mem)", i, sira[i], (i % 2 == 0) ? 1 : 0); end
    end
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_stall();
    int c, kalan;
    @(posedge clk_i); #1;
    c = -1; kalan = 3;
    getir_adres_i = 32'h2008; getir_oku_i = 1'b1; getir_asamasi_istek_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_i); #1;
      if (ram_istek_o && ram_adres_o[3:2] == 2'd2 && kalan > 0) begin
        stall = 1'b1; kalan--;
      end else begin
        stall = 1'b0;
      end
      if (stall) begin
        checks++; if (ram_adres_o !== 32'h2008 || ram_istek_o !== 1'b1) begin errors++; $display("FAIL stall_hold: got adr %h istek %b expected 00002008 1", ram_adres_o, ram_istek_o); end
      end
      if (getir_hazir === 1'b1) begin c = i; break; end
    end
    stall = 1'b0;
    checks++; if (c !== 8) begin errors++; $display("FAIL stall_latency: got %0d expected 8", c); end
    checks++; if (okunan_obek_o !== BLOK_D) begin errors++; $display("FAIL stall_obek: got %h expected %h", okunan_obek_o, BLOK_D); end
    bosalt();
    @(posedge clk_i);
  endtask

  task automatic test_reset_mid();
    int c;
    @(posedge clk_i); #1;
    getir_adres_i = 32'h1234; getir_oku_i = 1'b1; getir_asamasi_istek_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    checks++; if (ram_istek_o !== 1'b1 || ram_adres_o !== 32'h1234) begin errors++; $display("FAIL midrst_beat1: got istek %b adr %h expected 1 00001234", ram_istek_o, ram_adres_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if ({ram_istek_o, ram_yaz_o, getir_hazir, bellek_hazir} !== 4'b0) begin errors++; $display("FAIL midrst_async: got %b expected 0000", {ram_istek_o, ram_yaz_o, getir_hazir, bellek_hazir}); end
    checks++; if (anabellek_musait_o !== 1'b1 || ram_adres_o !== 32'h0 || okunan_obek_o !== 128'h0) begin errors++; $display("FAIL midrst_outputs: got musait %b adr %h obek %h expected 1 0 0", anabellek_musait_o, ram_adres_o, okunan_obek_o); end
    bosalt();
    @(negedge clk_i) rst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      checks++; if ({getir_hazir, bellek_hazir, ram_istek_o} !== 3'b0) begin errors++; $display("FAIL midrst_quiet%0d: got %b expected 000", i, {getir_hazir, bellek_hazir, ram_istek_o}); end
    end
    getir_adres_i = 32'h1234; getir_oku_i = 1'b1; getir_asamasi_istek_i = 1'b1;
    bekle_hazir(1'b0, c);
    checks++; if (c !== 5) begin errors++; $display("FAIL midrst_refetch_latency: got %0d expected 5", c); end
    checks++; if (okunan_obek_o !== BLOK_A) begin errors++; $display("FAIL midrst_refetch_obek: got %h expected %h", okunan_obek_o, BLOK_A); end
    bosalt();
    @(posedge clk_i);
  endtask

  task automatic test_malformed();
    int c, n0;
    logic [127:0] blk;
    blk = YAZ_2;
    @(posedge clk_i); #1;
    getir_adres_i = 32'h1234; getir_oku_i = 1'b0; getir_asamasi_istek_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++; if (anabellek_musait_o !== 1'b1 || ram_istek_o !== 1'b0) begin errors++; $display("FAIL bad_fetch_ignored%0d: got musait %b istek %b expected 1 0", i, anabellek_musait_o, ram_istek_o); end
    end
    bosalt();
    n0 = log_adres.size();
    bellek_adres_i = 32'h30C; bellek_yazilacak_obek_i = blk;
    bellek_oku_i = 1'b1; bellek_yaz_i = 1'b1; bellek_asamasi_istek_i = 1'b1;
    bekle_hazir(1'b1, c);
    checks++; if (c !== 5) begin errors++; $display("FAIL both_cmd_latency: got %0d expected 5", c); end
    checks++; if (okunan_obek_o !== BLOK_A) begin errors++; $display("FAIL both_cmd_obek_kept: got %h expected %h", okunan_obek_o, BLOK_A); end
    bosalt();
    @(posedge clk_i); #1;
    checks++; if (log_adres.size() - n0 !== 4) begin errors++; $display("FAIL both_cmd_beats: got %0d expected 4", log_adres.size() - n0); end
    for (int i = 0; i < 4 && n0 + i < log_adres.size(); i++) begin
      checks++;
      if (log_adres[n0+i] !== 32'h300 + 32'(4*i) || log_yaz[n0+i] !== 1'b1 || log_veri[n0+i] !== blk[32*i +: 32]) begin
        errors++; $display("FAIL both_cmd_beat%0d: got adr %h yaz %b data %h expected adr %h yaz 1 data %h",
                           i, log_adres[n0+i], log_yaz[n0+i], log_veri[n0+i], 32'h300 + 32'(4*i), blk[32*i +: 32]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hEE00_0000 | 32'(i);
    for (int i = 0; i < 4; i++) begin
      mem[8'h8C + i] = 32'hA0 + 32'(i);
      mem[8'h80 + i] = 32'hB0 + 32'(i);
      mem[8'hC0 + i] = 32'hC0 + 32'(i);
      mem[8'h00 + i] = 32'hD0 + 32'(i);
    end
    stall = 1'b0;
    getir_adres_i = '0;
    bellek_adres_i = '0;
    bellek_yazilacak_obek_i = '0;
    bosalt();

    test_reset();
    test_fetch_read();
    test_mem_write();
    test_simultaneous();
    test_stall();
    test_reset_mid();
    test_malformed();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
